// File: rtl/psum_acc_pkg.sv
// Shared types and helpers for the partial-sum accumulator: FSM state, width helpers
// and the rounding/saturating rescale used when a dot-product result forms.
package psum_acc_pkg;

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} psum_state_e;

  // Wide enough that round-then-shift never wraps for any practical accumulator width.
  localparam int CALC_W = 64;
  typedef logic signed [CALC_W-1:0] calc_t;

  typedef struct packed {
    logic  sat;
    calc_t data;
  } sat_res_t;

  function automatic int acc_width(input int tree_w, input int acc_len);
    return tree_w + $clog2(acc_len);
  endfunction

  function automatic int cnt_width(input int acc_len);
    return (acc_len > 1) ? $clog2(acc_len) : 1;
  endfunction

  // Half-up rounding arithmetic right shift, then clamp to a signed out_w range.
  function automatic sat_res_t sat_round(input calc_t value, input int unsigned shift,
                                         input int unsigned out_w);
    sat_res_t    res;
    calc_t       half;
    calc_t       r;
    calc_t       maxv;
    calc_t       minv;
    int unsigned s;
    s = (shift > 62) ? 62 : shift;
    if (s == 0) begin
      r = value;
    end else begin
      half = calc_t'(1) <<< (s - 1);
      r    = (value + half) >>> s;
    end
    maxv = (calc_t'(1) <<< (out_w - 1)) - calc_t'(1);
    minv = -maxv - calc_t'(1);
    if (r > maxv) begin
      res.sat  = 1'b1;
      res.data = maxv;
    end else if (r < minv) begin
      res.sat  = 1'b1;
      res.data = minv;
    end else begin
      res.sat  = 1'b0;
      res.data = r;
    end
    return res;
  endfunction

endpackage

// File: rtl/psum_accumulator_if.sv
// Handshake bundle between the adder tree / upstream source and the accumulator output side.
interface psum_accumulator_if #(
  parameter int TREE_OUT_WIDTH = 20,
  parameter int OUT_WIDTH      = 8
);
  logic                             in_valid;
  logic                             tree_en;
  logic signed [TREE_OUT_WIDTH-1:0] tree_sum;
  logic signed [OUT_WIDTH-1:0]      out_data;
  logic                             out_valid;
  logic                             out_ready;
  logic                             out_sat;

  modport master (
    output in_valid, tree_sum, out_ready,
    input  tree_en, out_data, out_valid, out_sat
  );

  modport slave (
    input  in_valid, tree_sum, out_ready,
    output tree_en, out_data, out_valid, out_sat
  );
endinterface

// File: rtl/tree_valid_tracker.sv
// Shadow valid pipe for an adder tree that carries no valid of its own; shifts and
// freezes in lockstep with the tree's add enable.
module tree_valid_tracker #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clear,
  input  logic vin,
  output logic vout
);

  logic [DEPTH-1:0] vpipe_q;
  logic [DEPTH-1:0] vpipe_d;

  always_comb begin
    vpipe_d = vpipe_q;
    if (clear) begin
      vpipe_d = '0;
    end else if (en) begin
      vpipe_d[0] = vin;
      for (int i = 1; i < DEPTH; i++) begin
        vpipe_d[i] = vpipe_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vpipe_q <= '0;
    else        vpipe_q <= vpipe_d;
  end

  assign vout = vpipe_q[DEPTH-1];

endmodule

// File: rtl/psum_accumulator.sv
// Accumulates ACC_LEN valid adder-tree sums into one rounded, saturated result and
// drives the tree enable for backpressure. Optional ReLU via PSUM_ACC_RELU_EN.
module psum_accumulator
  import psum_acc_pkg::*;
#(
  parameter int TREE_OUT_WIDTH = 20,
  parameter int TREE_LATENCY   = 4,
  parameter int ACC_LEN        = 8,
  parameter int OUT_WIDTH      = 8,
  parameter int SHIFT_W        = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic [SHIFT_W-1:0] shift,
  psum_accumulator_if.slave  bus
);

  localparam int ACC_WIDTH = acc_width(TREE_OUT_WIDTH, ACC_LEN);
  localparam int CNT_W     = cnt_width(ACC_LEN);

  typedef logic signed [ACC_WIDTH-1:0] acc_t;

  psum_state_e                 state_q, state_d;
  logic [CNT_W-1:0]            count_q, count_d;
  acc_t                        acc_q, acc_d;
  logic signed [OUT_WIDTH-1:0] out_data_q, out_data_d;
  logic                        out_sat_q, out_sat_d;

  logic                        tree_en;
  logic                        vlast;
  logic                        sum_take;
  logic                        last_sum;
  acc_t                        total;
  sat_res_t                    res;
  logic signed [OUT_WIDTH-1:0] res_data;
  logic                        unused_res_hi;

  // A pending, unaccepted result freezes the tree and the shadow valid pipe together.
  assign tree_en = !(state_q == HOLD && !bus.out_ready);

  tree_valid_tracker #(
    .DEPTH (TREE_LATENCY)
  ) u_vtrack (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (tree_en),
    .clear (clear),
    .vin   (bus.in_valid),
    .vout  (vlast)
  );

  assign sum_take = vlast && tree_en;
  assign last_sum = sum_take && (count_q == CNT_W'(ACC_LEN - 1));
  assign total    = ((count_q == '0) ? acc_t'(0) : acc_q) + acc_t'(bus.tree_sum);

  always_comb begin
    res      = sat_round(calc_t'(total), 32'(shift), OUT_WIDTH);
    res_data = res.data[OUT_WIDTH-1:0];
`ifdef PSUM_ACC_RELU_EN
    if (res.data[CALC_W-1]) res_data = '0;
`endif
  end

  assign unused_res_hi = ^res.data[CALC_W-1:OUT_WIDTH];

  always_comb begin
    count_d = count_q;
    acc_d   = acc_q;
    if (clear) begin
      count_d = '0;
      acc_d   = '0;
    end else if (sum_take) begin
      count_d = last_sum ? '0 : count_q + CNT_W'(1);
      acc_d   = total;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ACCUM;
    end else begin
      case (state_q)
        ACCUM:   if (last_sum) state_d = HOLD;
        HOLD:    if (bus.out_ready && !last_sum) state_d = ACCUM;
        default: state_d = ACCUM;
      endcase
    end
  end

  always_comb begin
    out_data_d = out_data_q;
    out_sat_d  = out_sat_q;
    if (clear) begin
      out_data_d = '0;
      out_sat_d  = 1'b0;
    end else if (last_sum) begin
      out_data_d = res_data;
      out_sat_d  = res.sat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ACCUM;
      count_q    <= '0;
      acc_q      <= '0;
      out_data_q <= '0;
      out_sat_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      acc_q      <= acc_d;
      out_data_q <= out_data_d;
      out_sat_q  <= out_sat_d;
    end
  end

  // FSM: outputs
  always_comb begin
    bus.tree_en   = tree_en;
    bus.out_valid = (state_q == HOLD);
    bus.out_data  = out_data_q;
    bus.out_sat   = out_sat_q;
  end

endmodule

// File: tb/tb_psum_accumulator.sv
// Randomized and directed bench for psum_accumulator with a behavioural adder-tree
// stand-in and a queue-based result model.
module tb_psum_accumulator;

  localparam int TW   = 20;
  localparam int LAT  = 4;
  localparam int ALEN = 4;
  localparam int OW   = 8;
  localparam int SW   = 5;
  localparam longint OMAX = (longint'(1) << (OW - 1)) - 1;
  localparam longint OMIN = -OMAX - 1;
`ifdef PSUM_ACC_RELU_EN
  localparam longint NEG_SAT = 0;
  localparam longint NEG_ONE = 0;
`else
  localparam longint NEG_SAT = -128;
  localparam longint NEG_ONE = -1;
`endif

  typedef struct {
    longint data;
    bit     sat;
  } res_t;

  logic                 clk   = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 clear = 1'b0;
  logic [SW-1:0]        shift = '0;
  logic signed [TW-1:0] din   = '0;
  logic signed [TW-1:0] tp [LAT] = '{default: '0};

  int     n_checks = 0;
  int     n_pass   = 0;
  res_t   expq[$];
  longint pend[$];
  bit     hold_valid = 0;
  longint hold_data  = 0;
  longint hold_sat   = 0;
  longint last_data  = 0;
  int     n_results  = 0;

  psum_accumulator_if #(.TREE_OUT_WIDTH(TW), .OUT_WIDTH(OW)) bus ();

  psum_accumulator #(
    .TREE_OUT_WIDTH (TW),
    .TREE_LATENCY   (LAT),
    .ACC_LEN        (ALEN),
    .OUT_WIDTH      (OW),
    .SHIFT_W        (SW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .shift (shift),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Adder-tree stand-in: a plain delay line that advances only on tree_en.
  always @(posedge clk) begin
    if (bus.tree_en) begin
      tp[0] <= din;
      for (int i = 1; i < LAT; i++) tp[i] <= tp[i-1];
    end
  end
  assign bus.tree_sum = tp[LAT-1];

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic res_t model_out(input longint t, input int s);
    res_t   r;
    longint n, dv, q;
    if (s == 0) begin
      q = t;
    end else begin
      dv = longint'(1) << s;
      n  = t + dv / 2;
      q  = n / dv;
      if ((n % dv != 0) && (n < 0)) q = q - 1;
    end
    if (q > OMAX) begin
      r.data = OMAX; r.sat = 1;
    end else if (q < OMIN) begin
      r.data = OMIN; r.sat = 1;
    end else begin
      r.data = q; r.sat = 0;
    end
`ifdef PSUM_ACC_RELU_EN
    if (r.data < 0) r.data = 0;
`endif
    return r;
  endfunction

  task automatic flush_model();
    pend.delete();
    expq.delete();
    hold_valid = 0;
  endtask

  task automatic cycle(input bit iv, input logic signed [TW-1:0] d, input bit clr,
                       input bit ordy);
    res_t   e;
    longint t;
    @(negedge clk);
    bus.in_valid  = iv;
    din           = d;
    clear         = clr;
    bus.out_ready = ordy;
    #1;
    check_eq("tree_en", longint'(bus.tree_en), (bus.out_valid && !ordy) ? 0 : 1);
    if (hold_valid) begin
      check_eq("hold_valid", longint'(bus.out_valid), 1);
      check_eq("hold_data", longint'(bus.out_data), hold_data);
      check_eq("hold_sat", longint'(bus.out_sat), hold_sat);
    end
    hold_valid = bus.out_valid && !ordy && !clr;
    hold_data  = longint'(bus.out_data);
    hold_sat   = longint'(bus.out_sat);
    if (clr) begin
      flush_model();
    end else begin
      if (bus.out_valid && ordy) begin
        check_eq("out_expected", longint'(expq.size() != 0), 1);
        if (expq.size() != 0) begin
          e = expq.pop_front();
          check_eq("out_data", longint'(bus.out_data), e.data);
          check_eq("out_sat", longint'(bus.out_sat), longint'(e.sat));
        end
        last_data = longint'(bus.out_data);
        n_results++;
      end
      if (iv && bus.tree_en) begin
        pend.push_back(longint'(d));
        if (pend.size() == ALEN) begin
          t = 0;
          foreach (pend[i]) t += pend[i];
          expq.push_back(model_out(t, int'(shift)));
          pend.delete();
        end
      end
    end
  endtask

  task automatic drain();
    repeat (20) cycle(0, TW'($urandom), 0, 1);
    check_eq("drain_left", longint'(expq.size()), 0);
  endtask

  task automatic directed4(input longint a, input longint b, input longint c, input longint e,
                           input longint exp_d, input longint exp_sat, input string tag,
                           input bit chk_lat);
    longint v[4];
    int     n;
    v = '{a, b, c, e};
    cycle(0, '0, 1, 1);
    for (int i = 0; i < 4; i++) cycle(1, TW'(v[i]), 0, 0);
    n = 4;
    while (!bus.out_valid && n < 30) begin
      cycle(0, TW'($urandom), 0, 0);
      n++;
    end
    if (chk_lat) check_eq({tag, "_latency"}, longint'(n), 9);
    check_eq({tag, "_valid"}, longint'(bus.out_valid), 1);
    check_eq({tag, "_data"}, longint'(bus.out_data), exp_d);
    check_eq({tag, "_sat"}, longint'(bus.out_sat), exp_sat);
    cycle(0, '0, 0, 1);
  endtask

  task automatic random_seg(input int s, input int ncyc);
    logic signed [TW-1:0] d;
    shift = SW'(s);
    for (int i = 0; i < ncyc; i++) begin
      if ($urandom_range(0, 3) == 0) d = TW'($urandom);
      else                           d = TW'(int'($urandom_range(0, 600)) - 300);
      cycle($urandom_range(0, 3) != 0, d, $urandom_range(0, 99) == 0,
            $urandom_range(0, 3) != 0);
    end
    drain();
  endtask

  initial begin
    int r0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_out_valid", longint'(bus.out_valid), 0);
    check_eq("rst_out_data", longint'(bus.out_data), 0);
    check_eq("rst_out_sat", longint'(bus.out_sat), 0);
    check_eq("rst_tree_en", longint'(bus.tree_en), 1);
    rst_n = 1'b1;

    directed4(10, 20, 30, 40, 100, 0, "basic", 1);
    directed4(100, 100, 100, 100, 127, 1, "pos_sat", 0);
    directed4(-100, -100, -100, -100, NEG_SAT, 1, "neg_sat", 0);
    shift = SW'(2);
    directed4(1, 1, 1, 3, 2, 0, "round_pos", 0);
    directed4(-1, -1, -1, -3, NEG_ONE, 0, "round_neg", 0);
    shift = '0;

    // Backpressure: result held for 10 cycles while upstream holds a beat.
    directed4(1, 2, 3, 4, 10, 0, "pre_stall", 0);
    for (int i = 0; i < 4; i++) cycle(1, TW'(i + 5), 0, 1);
    for (int i = 0; i < 10; i++) cycle(1, TW'(9), 0, 0);
    for (int i = 0; i < 4; i++) cycle(1, TW'(9), 0, 1);
    drain();
    check_eq("stall_last", last_data, 36);

    // Bubbles between valid beats.
    cycle(0, '0, 1, 1);
    r0 = n_results;
    for (int i = 0; i < 8; i++) cycle((i % 2) == 0, TW'(i + 1), 0, 1);
    drain();
    check_eq("bubble_count", longint'(n_results - r0), 1);
    check_eq("bubble_val", last_data, 16);

    // Clear with beats still in flight inside the tree.
    cycle(1, TW'(7), 0, 1);
    cycle(1, TW'(7), 0, 1);
    cycle(0, '0, 1, 1);
    for (int i = 0; i < 4; i++) cycle(1, TW'(5), 0, 1);
    drain();
    check_eq("clear_val", last_data, 20);

    // Asynchronous reset with a result pending and beats in flight.
    cycle(0, '0, 1, 1);
    for (int i = 0; i < 6; i++) cycle(1, TW'(3), 0, 0);
    repeat (6) cycle(0, '0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_out_valid", longint'(bus.out_valid), 0);
    check_eq("arst_out_data", longint'(bus.out_data), 0);
    check_eq("arst_out_sat", longint'(bus.out_sat), 0);
    check_eq("arst_tree_en", longint'(bus.tree_en), 1);
    flush_model();
    repeat (2) cycle(0, '0, 0, 1);
    rst_n = 1'b1;
    directed4(4, 5, 6, 7, 22, 0, "post_rst", 0);

    random_seg(0, 800);
    random_seg(3, 800);
    random_seg(9, 800);
    random_seg(25, 300);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
